interval_timer: RTL and testbench

INTERVAL_TIMER -- requirements
Module: interval_timer

---
 rtl/interval_timer.sv | 136 +++++++++++++
 tb/tb_interval_timer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// Interval timer: a down-counter with a programmable period.
// It counts qualified ticks, raises a one-cycle Expired pulse on each
// expiry, and keeps sticky Irq/Overrun flags until they are acknowledged.
// In periodic mode the count reloads from the period register on expiry.
// In one-shot mode the timer falls back to IDLE on expiry.
module interval_timer #(
  parameter int width       = 16,
  parameter int auto_reload = 1
) (
  input  logic             GlobalClock,
  input  logic             clear_n,
  input  logic             ClockEnable,
  input  logic             Enable,
  input  logic             load,
  input  logic [width-1:0] LoadData,
  input  logic             start,
  input  logic             stop,
  input  logic             IrqAck,
  output logic [width-1:0] CountValue,
  output logic             Running,
  output logic             Expired,
  output logic             Irq,
  output logic             Overrun
);

  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       RUN      = 1'b1;
  localparam logic [width-1:0] ZERO     = '0;
  localparam logic [width-1:0] ONE      = width'(1);
  localparam logic             periodic = 1'(auto_reload != 0);

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [width-1:0] period_reg;
  logic [width-1:0] count_next;
  logic [width-1:0] eff_period;
  logic             tick;
  logic             start_ok;
  logic             at_last;
  logic             expiry;
  logic             reload_ok;
  logic             irq_next;
  logic             overrun_next;

  // Decode the per-cycle qualifiers: tick, effective period and expiry.
  // stop and a valid start both pre-empt a same-cycle expiry.
  always_comb begin
    tick       = ClockEnable & Enable;
    eff_period = load ? LoadData : period_reg;
    start_ok   = start & (eff_period != ZERO);
    at_last    = (CountValue == ONE);
    expiry     = (state == RUN) & tick & at_last & ~stop & ~start_ok;
    reload_ok  = periodic & (period_reg != ZERO);
  end

  // Next state and count: stop beats start, start beats counting.
  // A reload value of zero would leave RUN holding a dead count, so it ends the run instead.
  always_comb begin
    state_next = state;
    count_next = CountValue;
    if (stop) begin
      state_next = IDLE;
      count_next = ZERO;
    end else if (start_ok) begin
      state_next = RUN;
      count_next = eff_period;
    end else begin
      case (state)
        RUN: begin
          if (tick) begin
            if (at_last) begin
              if (reload_ok) begin
                count_next = period_reg;
              end else begin
                state_next = IDLE;
                count_next = ZERO;
              end
            end else begin
              count_next = CountValue - ONE;
            end
          end
        end
        IDLE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          count_next = ZERO;
        end
      endcase
    end
  end

  // Sticky flags: an acknowledge clears them; an expiry sets Irq.
  // Overrun is set only when an unacknowledged Irq is already pending.
  always_comb begin
    irq_next     = (Irq & ~IrqAck) | expiry;
    overrun_next = (Overrun & ~IrqAck) | (expiry & Irq & ~IrqAck);
  end

  // FSM state and remaining-count register.
  always_ff @(posedge GlobalClock or negedge clear_n) begin
    if (!clear_n) begin
      state      <= IDLE;
      CountValue <= ZERO;
    end else begin
      state      <= state_next;
      CountValue <= count_next;
    end
  end

  // The period register takes every load, in any state; a running count sees it at the next reload or start.
  always_ff @(posedge GlobalClock or negedge clear_n) begin
    if (!clear_n) begin
      period_reg <= ZERO;
    end else if (load) begin
      period_reg <= LoadData;
    end
  end

  // Registered expiry pulse plus the sticky interrupt flags.
  always_ff @(posedge GlobalClock or negedge clear_n) begin
    if (!clear_n) begin
      Expired <= 1'b0;
      Irq     <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      Expired <= expiry;
      Irq     <= irq_next;
      Overrun <= overrun_next;
    end
  end

  assign Running = (state == RUN);

endmodule

// File: tb/tb_interval_timer.sv
// Testbench for interval_timer.
// It runs a periodic instance and a one-shot instance side by side.
// Directed vectors and hand sequences use fixed expected values.
// Random stimulus is compared against a cycle-level behavioural model.
module tb_interval_timer;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         GlobalClock = 1'b0;
  logic         clear_n;
  logic         ClockEnable;
  logic         Enable;
  logic         load;
  logic [W-1:0] LoadData;
  logic         start;
  logic         stop;
  logic         IrqAck;

  logic [W-1:0] p_count;
  logic         p_running;
  logic         p_expired;
  logic         p_irq;
  logic         p_overrun;
  logic [W-1:0] o_count;
  logic         o_running;
  logic         o_expired;
  logic         o_irq;
  logic         o_overrun;

  int errors = 0;
  int checks = 0;

  // Reference model state; index 0 = periodic, 1 = one-shot
  int m_count[2];
  int m_period[2];
  bit m_run[2];
  bit m_exp[2];
  bit m_irq[2];
  bit m_ov[2];

  typedef struct {
    bit st;  bit sp;  bit ld;  int data;
    bit ce;  bit en;  bit ack;
    int count; bit run; bit exp; bit irq; bit ov;
  } vec_t;

  vec_t vecs[$];

  always #5 GlobalClock = ~GlobalClock;

  interval_timer #(.width(W), .auto_reload(1)) dut_periodic (
    .GlobalClock(GlobalClock), .clear_n(clear_n), .ClockEnable(ClockEnable),
    .Enable(Enable), .load(load), .LoadData(LoadData), .start(start),
    .stop(stop), .IrqAck(IrqAck), .CountValue(p_count), .Running(p_running),
    .Expired(p_expired), .Irq(p_irq), .Overrun(p_overrun)
  );

  interval_timer #(.width(W), .auto_reload(0)) dut_oneshot (
    .GlobalClock(GlobalClock), .clear_n(clear_n), .ClockEnable(ClockEnable),
    .Enable(Enable), .load(load), .LoadData(LoadData), .start(start),
    .stop(stop), .IrqAck(IrqAck), .CountValue(o_count), .Running(o_running),
    .Expired(o_expired), .Irq(o_irq), .Overrun(o_overrun)
  );

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0; m_period[i] = 0; m_run[i] = 0;
      m_exp[i] = 0; m_irq[i] = 0; m_ov[i] = 0;
    end
  endtask

  // One clock edge of the behavioural timer, from the inputs currently applied
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int cnt;
      int per;
      int eff;
      bit run;
      bit tick;
      bit nexp;
      bit nirq;
      bit nov;
      cnt  = m_count[i];
      per  = m_period[i];
      run  = m_run[i];
      tick = ClockEnable && Enable;
      eff  = load ? int'(LoadData) : per;
      nexp = 0;
      nirq = IrqAck ? 1'b0 : m_irq[i];
      nov  = IrqAck ? 1'b0 : m_ov[i];
      if (stop) begin
        run = 0; cnt = 0;
      end else if (start && eff != 0) begin
        run = 1; cnt = eff;
      end else if (m_run[i] && tick) begin
        if (cnt == 1) begin
          nexp = 1;
          nirq = 1;
          if (m_irq[i] && !IrqAck) nov = 1;
          if (i == 0 && per != 0) cnt = per;
          else begin run = 0; cnt = 0; end
        end else begin
          cnt = (cnt - 1) & MASK;
        end
      end
      if (load) m_period[i] = int'(LoadData);
      m_count[i] = cnt; m_run[i] = run; m_exp[i] = nexp;
      m_irq[i] = nirq;  m_ov[i] = nov;
    end
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input bit ld, input int data,
                               input bit ce, input bit en, input bit ack);
    start = st; stop = sp; load = ld; LoadData = W'(data);
    ClockEnable = ce; Enable = en; IrqAck = ack;
    @(posedge GlobalClock);
    model_step();
    #1;
  endtask

  task automatic compareOneshot(input string tag);
    checkOutput({tag, ".o.count"},   o_count,   m_count[1]);
    checkOutput({tag, ".o.running"}, o_running, m_run[1]);
    checkOutput({tag, ".o.expired"}, o_expired, m_exp[1]);
    checkOutput({tag, ".o.irq"},     o_irq,     m_irq[1]);
    checkOutput({tag, ".o.overrun"}, o_overrun, m_ov[1]);
  endtask

  task automatic compareModels(input string tag);
    checkOutput({tag, ".p.count"},   p_count,   m_count[0]);
    checkOutput({tag, ".p.running"}, p_running, m_run[0]);
    checkOutput({tag, ".p.expired"}, p_expired, m_exp[0]);
    checkOutput({tag, ".p.irq"},     p_irq,     m_irq[0]);
    checkOutput({tag, ".p.overrun"}, p_overrun, m_ov[0]);
    compareOneshot(tag);
  endtask

  initial begin
    // Directed vectors for the periodic instance:
    // st sp ld data ce en ack | count run exp irq ov
    vecs.push_back('{1,0,1,3,1,1,0, 3,1,0,0,0});
    vecs.push_back('{0,0,0,0,1,1,0, 2,1,0,0,0});
    vecs.push_back('{0,0,0,0,1,1,0, 1,1,0,0,0});
    vecs.push_back('{0,0,0,0,1,1,0, 3,1,1,1,0});
    vecs.push_back('{0,0,0,0,1,1,0, 2,1,0,1,0});
    vecs.push_back('{0,0,0,0,1,1,0, 1,1,0,1,0});
    vecs.push_back('{0,0,0,0,1,1,0, 3,1,1,1,1});
    vecs.push_back('{0,0,0,0,1,1,1, 2,1,0,0,0});
    vecs.push_back('{0,0,0,0,0,1,0, 2,1,0,0,0});
    vecs.push_back('{0,0,0,0,1,0,0, 2,1,0,0,0});
    vecs.push_back('{0,0,0,0,1,1,0, 1,1,0,0,0});
    vecs.push_back('{0,0,0,0,1,1,1, 3,1,1,1,0});
    vecs.push_back('{0,0,0,0,1,1,0, 2,1,0,1,0});
    vecs.push_back('{0,0,0,0,1,1,0, 1,1,0,1,0});
    vecs.push_back('{0,1,0,0,1,1,0, 0,0,0,1,0});
    vecs.push_back('{1,0,0,0,0,1,0, 3,1,0,1,0});
    vecs.push_back('{0,0,1,5,1,1,0, 2,1,0,1,0});
    vecs.push_back('{0,0,0,0,1,1,0, 1,1,0,1,0});
    vecs.push_back('{0,0,0,0,1,1,0, 5,1,1,1,1});
    vecs.push_back('{1,1,0,0,1,1,0, 0,0,0,1,1});
    vecs.push_back('{1,0,1,0,1,1,0, 0,0,0,1,1});
    vecs.push_back('{1,0,0,0,1,1,0, 0,0,0,1,1});
    vecs.push_back('{0,0,0,0,0,1,1, 0,0,0,0,0});

    clear_n = 1'b0;
    start = 0; stop = 0; load = 0; LoadData = '0;
    ClockEnable = 0; Enable = 0; IrqAck = 0;
    model_reset();
    repeat (2) @(posedge GlobalClock);
    #1;
    checkOutput("reset.count",   p_count,   0);
    checkOutput("reset.running", p_running, 0);
    checkOutput("reset.expired", p_expired, 0);
    checkOutput("reset.irq",     p_irq,     0);
    checkOutput("reset.overrun", p_overrun, 0);
    checkOutput("reset.o.count", o_count,   0);
    clear_n = 1'b1;

    // Table-driven directed vectors
    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].st, vecs[v].sp, vecs[v].ld, vecs[v].data,
                    vecs[v].ce, vecs[v].en, vecs[v].ack);
      checkOutput($sformatf("vec%0d.count", v),   p_count,   vecs[v].count);
      checkOutput($sformatf("vec%0d.running", v), p_running, vecs[v].run);
      checkOutput($sformatf("vec%0d.expired", v), p_expired, vecs[v].exp);
      checkOutput($sformatf("vec%0d.irq", v),     p_irq,     vecs[v].irq);
      checkOutput($sformatf("vec%0d.overrun", v), p_overrun, vecs[v].ov);
      compareOneshot($sformatf("vec%0d", v));
    end

    // One-shot: period 2, two ticks, single expiry then IDLE
    applyStimulus(1,0,1,2,1,1,1);
    checkOutput("oneshot.start.count", o_count, 2);
    checkOutput("oneshot.start.running", o_running, 1);
    applyStimulus(0,0,0,0,1,1,0);
    checkOutput("oneshot.t1.count", o_count, 1);
    applyStimulus(0,0,0,0,1,1,0);
    checkOutput("oneshot.t2.count",   o_count,   0);
    checkOutput("oneshot.t2.running", o_running, 0);
    checkOutput("oneshot.t2.expired", o_expired, 1);
    checkOutput("oneshot.t2.irq",     o_irq,     1);
    applyStimulus(0,0,0,0,0,1,0);
    checkOutput("oneshot.after.expired", o_expired, 0);
    checkOutput("oneshot.after.irq",     o_irq,     1);

    // Periodic overrun: two expiries without acknowledge, then acknowledge
    applyStimulus(1,0,1,2,1,1,1);
    checkOutput("overrun.start.irq", p_irq, 0);
    applyStimulus(0,0,0,0,1,1,0);
    applyStimulus(0,0,0,0,1,1,0);
    checkOutput("overrun.e1.count",   p_count,   2);
    checkOutput("overrun.e1.expired", p_expired, 1);
    checkOutput("overrun.e1.overrun", p_overrun, 0);
    applyStimulus(0,0,0,0,1,1,0);
    checkOutput("overrun.e1next.expired", p_expired, 0);
    applyStimulus(0,0,0,0,1,1,0);
    checkOutput("overrun.e2.irq",     p_irq,     1);
    checkOutput("overrun.e2.overrun", p_overrun, 1);
    applyStimulus(0,0,0,0,0,1,1);
    checkOutput("overrun.ack.irq",     p_irq,     0);
    checkOutput("overrun.ack.overrun", p_overrun, 0);

    // Enable low for 5 cycles holds the count, then stop beats a same-cycle expiry
    applyStimulus(1,0,1,4,1,1,0);
    applyStimulus(0,0,0,0,1,1,0);
    applyStimulus(0,0,0,0,1,1,0);
    checkOutput("hold.pre.count", p_count, 2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0,0,0,0,1,0,0);
      checkOutput($sformatf("hold%0d.count", k),   p_count,   2);
      checkOutput($sformatf("hold%0d.running", k), p_running, 1);
    end
    applyStimulus(0,0,0,0,1,1,0);
    checkOutput("hold.post.count", p_count, 1);
    applyStimulus(0,1,0,0,1,1,0);
    checkOutput("stopexp.count",   p_count,   0);
    checkOutput("stopexp.running", p_running, 0);
    checkOutput("stopexp.expired", p_expired, 0);
    checkOutput("stopexp.irq",     p_irq,     0);

    // Asynchronous reset mid-count, then start with the cleared period
    applyStimulus(1,0,1,5,1,1,0);
    applyStimulus(0,0,0,0,1,1,0);
    checkOutput("areset.pre.count", p_count, 4);
    #2;
    clear_n = 1'b0;
    #1;
    model_reset();
    checkOutput("areset.count",   p_count,   0);
    checkOutput("areset.running", p_running, 0);
    checkOutput("areset.expired", p_expired, 0);
    checkOutput("areset.irq",     p_irq,     0);
    checkOutput("areset.overrun", p_overrun, 0);
    checkOutput("areset.o.count", o_count,   0);
    #2;
    clear_n = 1'b1;
    applyStimulus(1,0,0,0,1,1,0);
    checkOutput("zeroperiod.running",   p_running, 0);
    checkOutput("zeroperiod.o.running", o_running, 0);
    checkOutput("zeroperiod.count",     p_count,   0);

    // Randomized stimulus against the behavioural model
    for (int n = 0; n < 2000; n++) begin
      bit st, sp, ld, ce, en, ack;
      int data;
      st   = ($urandom_range(0, 7) == 0);
      sp   = ($urandom_range(0, 19) == 0);
      ld   = ($urandom_range(0, 7) == 0);
      data = $urandom_range(0, 6);
      ce   = ($urandom_range(0, 3) != 0);
      en   = ($urandom_range(0, 7) != 0);
      ack  = ($urandom_range(0, 9) == 0);
      applyStimulus(st, sp, ld, data, ce, en, ack);
      compareModels($sformatf("rnd%0d", n));
      if (n % 500 == 499) begin
        #2;
        clear_n = 1'b0;
        #1;
        model_reset();
        compareModels($sformatf("rndreset%0d", n));
        #2;
        clear_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
